// File: rtl/wb_per16_bridge.sv
// Wishbone classic slave to openMSP430 16-bit peripheral-bus bridge.
// Handles one transaction at a time. Every output comes straight from a flop.
module wb_per16_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter logic [31:0] ADDR_MASK = 32'hFFFF_8000,
    parameter int unsigned RD_DLY    = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [13:0] per_addr_o,
    output logic [15:0] per_din_o,
    output logic [1:0]  per_we_o,
    output logic        per_en_o,
    input  logic [15:0] per_dout_i
);

    localparam int unsigned CNT_W = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_ACK
    } state_t;

    state_t             state;
    logic               is_wr;
    logic               guard;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        rd_q;
    logic               hit;

    // Upper byte selects and upper write-data half have no destination on a 16-bit bus.
    logic unused_ok;
    assign unused_ok = ^{wbs_sel_i[3:2], wbs_dat_i[31:16]};

    // Address decode for the 32 KB window.
    assign hit = wbs_cyc_i & wbs_stb_i &
                 ((wbs_adr_i & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));

    // Read data is zero outside the ack cycle, so the upper half is a constant.
    assign wbs_dat_o = {16'h0000, rd_q};

    // Bridge FSM: IDLE -> ACCESS -> [WAIT] -> ACK -> IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= S_IDLE;
            is_wr      <= 1'b0;
            guard      <= 1'b0;
            cnt        <= '0;
            rd_q       <= 16'h0000;
            wbs_ack_o  <= 1'b0;
            per_addr_o <= 14'h0000;
            per_din_o  <= 16'h0000;
            per_we_o   <= 2'b00;
            per_en_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // The first IDLE cycle after an ack ignores a still-asserted strobe.
                    guard <= 1'b0;
                    if (hit && !guard) begin
                        per_addr_o <= wbs_adr_i[14:1];
                        per_din_o  <= wbs_dat_i[15:0];
                        per_we_o   <= wbs_we_i ? wbs_sel_i[1:0] : 2'b00;
                        // A write touching only the upper half is dropped but still acked.
                        per_en_o   <= !wbs_we_i || (wbs_sel_i[1:0] != 2'b00);
                        is_wr      <= wbs_we_i;
                        state      <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    per_en_o <= 1'b0;
                    if (!wbs_cyc_i) begin
                        state <= S_IDLE;
                    end else if (is_wr) begin
                        wbs_ack_o <= 1'b1;
                        rd_q      <= 16'h0000;
                        state     <= S_ACK;
                    end else if (RD_DLY == 0) begin
                        wbs_ack_o <= 1'b1;
                        rd_q      <= per_dout_i;
                        state     <= S_ACK;
                    end else begin
                        cnt   <= CNT_W'(RD_DLY);
                        state <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (!wbs_cyc_i) begin
                        state <= S_IDLE;
                    end else if (cnt == CNT_W'(1)) begin
                        wbs_ack_o <= 1'b1;
                        rd_q      <= per_dout_i;
                        state     <= S_ACK;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                S_ACK: begin
                    wbs_ack_o <= 1'b0;
                    rd_q      <= 16'h0000;
                    guard     <= 1'b1;
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_per16_bridge.sv
// Bench for wb_per16_bridge: three instances (RD_DLY 0, 2, 3) on one shared Wishbone bus.
module tb_wb_per16_bridge;

    localparam int unsigned NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic [15:0] dout;

    logic        ack_v   [NDUT];
    logic [31:0] dato_v  [NDUT];
    logic [13:0] paddr_v [NDUT];
    logic [15:0] pdin_v  [NDUT];
    logic [1:0]  pwe_v   [NDUT];
    logic        pen_v   [NDUT];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_per16_bridge #(.RD_DLY(0)) u0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_v[0]),
        .wbs_dat_o(dato_v[0]), .per_addr_o(paddr_v[0]), .per_din_o(pdin_v[0]),
        .per_we_o(pwe_v[0]), .per_en_o(pen_v[0]), .per_dout_i(dout));

    wb_per16_bridge #(.RD_DLY(2)) u1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_v[1]),
        .wbs_dat_o(dato_v[1]), .per_addr_o(paddr_v[1]), .per_din_o(pdin_v[1]),
        .per_we_o(pwe_v[1]), .per_en_o(pen_v[1]), .per_dout_i(dout));

    wb_per16_bridge #(.RD_DLY(3)) u2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack_v[2]),
        .wbs_dat_o(dato_v[2]), .per_addr_o(paddr_v[2]), .per_din_o(pdin_v[2]),
        .per_we_o(pwe_v[2]), .per_en_o(pen_v[2]), .per_dout_i(dout));

    typedef struct {
        int          d;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [15:0] dv;
        logic        hit;
        logic        en;
        logic [13:0] paddr;
        logic [15:0] pdin;
        logic [1:0]  pwe;
        int          lat;
        logic [31:0] rdat;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] dat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];

    function automatic int dly_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
    endtask

    // One transaction on instance v.d; expected ack latency/data go through the scoreboard.
    task automatic run_vec(input string tag, input vec_t v);
        int          en_cnt  = 0;
        int          ack_cnt = 0;
        bit          dat_bad = 0;
        logic [13:0] a_seen  = '0;
        logic [15:0] d_seen  = '0;
        logic [1:0]  w_seen  = '0;
        exp_t        e;
        int          dly     = dly_of(v.d);
        if (v.hit) sb.push_back('{lat: v.lat, dat: v.rdat});
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = v.we; sel = v.sel; adr = v.adr; wdat = v.wdat;
        dout = 16'h5555;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            dout = (k == 1 + dly) ? v.dv : 16'h5555;
            if (pen_v[v.d]) begin
                en_cnt++;
                a_seen = paddr_v[v.d];
                d_seen = pdin_v[v.d];
                w_seen = pwe_v[v.d];
            end
            if (ack_v[v.d]) begin
                ack_cnt++;
                if (sb.size() == 0) begin
                    chk({tag, "_unexpected_ack_cycle"}, 64'(k), 64'(0));
                end else begin
                    e = sb.pop_front();
                    chk({tag, "_ack_latency"}, 64'(k), 64'(e.lat));
                    chk({tag, "_ack_data"}, 64'(dato_v[v.d]), 64'(e.dat));
                end
                bus_idle();
            end else if (dato_v[v.d] != 32'h0) begin
                dat_bad = 1'b1;
            end
        end
        bus_idle();
        chk({tag, "_en_count"}, 64'(en_cnt), v.en ? 64'(1) : 64'(0));
        if (v.en) begin
            chk({tag, "_per_addr"}, 64'(a_seen), 64'(v.paddr));
            chk({tag, "_per_din"}, 64'(d_seen), 64'(v.pdin));
            chk({tag, "_per_we"}, 64'(w_seen), 64'(v.pwe));
        end
        chk({tag, "_ack_count"}, 64'(ack_cnt), v.hit ? 64'(1) : 64'(0));
        chk({tag, "_dat_zero_off_ack"}, 64'(dat_bad), 64'(0));
        chk({tag, "_scoreboard_drained"}, 64'(sb.size()), 64'(0));
        sb.delete();
    endtask

    initial begin
        int ack_cnt;
        int en_cnt;
        vec_t rv;

        //        d  we    sel    adr            wdat           dv       hit   en    paddr     pdin      pwe    lat rdat
        vt.push_back('{0, 1'b1, 4'hF, 32'h3000_0010, 32'hDEAD_BEEF, 16'h0000, 1'b1, 1'b1, 14'h0008, 16'hBEEF, 2'b11, 2, 32'h0});
        vt.push_back('{0, 1'b1, 4'h2, 32'h3000_0102, 32'h1111_22CC, 16'h0000, 1'b1, 1'b1, 14'h0081, 16'h22CC, 2'b10, 2, 32'h0});
        vt.push_back('{0, 1'b1, 4'hC, 32'h3000_0200, 32'hCAFE_F00D, 16'h0000, 1'b1, 1'b0, 14'h0000, 16'h0000, 2'b00, 2, 32'h0});
        vt.push_back('{0, 1'b0, 4'hF, 32'h3000_7FFE, 32'h0000_0000, 16'h1234, 1'b1, 1'b1, 14'h3FFF, 16'h0000, 2'b00, 2, 32'h0000_1234});
        vt.push_back('{1, 1'b0, 4'hF, 32'h3000_0040, 32'h0000_0000, 16'hA5A5, 1'b1, 1'b1, 14'h0020, 16'h0000, 2'b00, 4, 32'h0000_A5A5});
        vt.push_back('{2, 1'b0, 4'h3, 32'h3000_0002, 32'h0000_0000, 16'h0F0F, 1'b1, 1'b1, 14'h0001, 16'h0000, 2'b00, 5, 32'h0000_0F0F});
        vt.push_back('{1, 1'b1, 4'h1, 32'h3000_7FFF, 32'h0000_ABCD, 16'h0000, 1'b1, 1'b1, 14'h3FFF, 16'hABCD, 2'b01, 2, 32'h0});
        vt.push_back('{0, 1'b0, 4'hF, 32'h3000_8000, 32'h0000_0000, 16'h1111, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00, 0, 32'h0});
        vt.push_back('{0, 1'b1, 4'hF, 32'h2000_0000, 32'h1234_5678, 16'h0000, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00, 0, 32'h0});

        bus_idle();
        dout = 16'h0000;
        rst  = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < int'(NDUT); i++) begin
            chk($sformatf("reset_ctrl_dut%0d", i),
                64'({ack_v[i], pen_v[i], pwe_v[i], paddr_v[i], pdin_v[i]}), 64'(0));
            chk($sformatf("reset_dat_dut%0d", i), 64'(dato_v[i]), 64'(0));
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        foreach (vt[i]) run_vec($sformatf("vec%0d", i), vt[i]);

        // Abort: drop cyc while the RD_DLY=3 instance is waiting.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h3000_0004;
        @(negedge clk);
        chk("abort_en_issued", 64'(pen_v[2]), 64'(1));
        @(negedge clk);
        bus_idle();
        ack_cnt = 0;
        en_cnt  = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack_v[2]) ack_cnt++;
            if (pen_v[2]) en_cnt++;
        end
        chk("abort_no_ack", 64'(ack_cnt), 64'(0));
        chk("abort_no_extra_en", 64'(en_cnt), 64'(0));
        rv = '{2, 1'b0, 4'hF, 32'h3000_0006, 32'h0, 16'h6B6B, 1'b1, 1'b1, 14'h0003, 16'h0000, 2'b00, 5, 32'h0000_6B6B};
        run_vec("after_abort", rv);

        // Reset while the access strobe is out.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h3000_0020; wdat = 32'h0000_7777;
        @(negedge clk);
        chk("rst_mid_en_before", 64'(pen_v[2]), 64'(1));
        chk("rst_mid_addr_before", 64'(paddr_v[2]), 64'(14'h0010));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack", 64'(ack_v[2]), 64'(0));
        chk("rst_mid_en", 64'(pen_v[2]), 64'(0));
        chk("rst_mid_we", 64'(pwe_v[2]), 64'(0));
        chk("rst_mid_addr", 64'(paddr_v[2]), 64'(0));
        chk("rst_mid_din", 64'(pdin_v[2]), 64'(0));
        chk("rst_mid_dat", 64'(dato_v[2]), 64'(0));
        rst = 1'b0;
        bus_idle();
        ack_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack_v[2]) ack_cnt++;
        end
        chk("rst_mid_no_ack", 64'(ack_cnt), 64'(0));
        rv = '{2, 1'b0, 4'hF, 32'h3000_0100, 32'h0, 16'hC3C3, 1'b1, 1'b1, 14'h0080, 16'h0000, 2'b00, 5, 32'h0000_C3C3};
        run_vec("after_reset", rv);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
